// File: rtl/aes_cbc_decrypt_chain.sv
// CBC decrypt chaining around an external combinational AES core; one block in flight, pt valid WAIT_CYCLES after accept.
// Define AES_CBC_CHAIN_EN for CBC chaining; left undefined the block is an ECB passthrough and iv/iv_load are unused.
module aes_cbc_decrypt_chain #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         iv_load,
   input  logic [127:0] iv,
   input  logic         ct_valid,
   output logic         ct_ready,
   input  logic [127:0] ct,
   output logic [127:0] dec_in,
   input  logic [127:0] dec_out,
   output logic         pt_valid,
   input  logic         pt_ready,
   output logic [127:0] pt,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

   state_t       state, state_nxt;
   logic [3:0]   cnt;
   logic         accept, capture, out_done;
   logic [127:0] pt_nxt;

`ifdef AES_CBC_CHAIN_EN
   logic [127:0] chain;

   // iv_load wins over a simultaneous ciphertext offer
   assign ct_ready = (state == IDLE) && !iv_load;
   assign pt_nxt   = dec_out ^ chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else if (state == IDLE && iv_load) begin
         chain <= iv;
      end else if (capture) begin
         chain <= dec_in;
      end
   end
`else
   logic unused_iv;

   assign unused_iv = ^{iv_load, iv};
   assign ct_ready  = (state == IDLE);
   assign pt_nxt    = dec_out;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      out_done  = 1'b0;
      case (state)
         IDLE: begin
            if (ct_valid && ct_ready) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (pt_ready) begin
               out_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         dec_in   <= '0;
         pt       <= '0;
         pt_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         // dec_in only moves on acceptance so the core input is stable for the whole wait
         if (accept) begin
            dec_in <= ct;
            cnt    <= 4'(WAIT_CYCLES - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            pt       <= pt_nxt;
            pt_valid <= 1'b1;
         end else if (out_done) begin
            pt_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_aes_cbc_decrypt_chain.sv
// Scoreboard bench for aes_cbc_decrypt_chain; a stand-in AES core maps the known test ciphertext to its plaintext.
// Follows AES_CBC_CHAIN_EN to choose the CBC or ECB reference model.
module tb_aes_cbc_decrypt_chain;
   localparam int W = 2;
   localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0, rst = 1'b1, iv_load = 1'b0, ct_valid = 1'b0, pt_ready = 1'b0;
   logic [127:0] iv = '0, ct = '0, dec_out;
   logic         ct_ready, pt_valid, busy;
   logic [127:0] dec_in, pt;

   int checks = 0, failures = 0, cyc = 0;

   typedef struct {
      logic [127:0] pt;
      int           cyc;
   } exp_t;
   exp_t         exp_q[$];
   logic [127:0] chain_m = '0;

   aes_cbc_decrypt_chain #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .iv_load(iv_load), .iv(iv),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct(ct),
      .dec_in(dec_in), .dec_out(dec_out),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt(pt), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] core(input logic [127:0] x);
      if (x == KAT_CT) return KAT_PT;
      return {x[63:0], x[127:64]} ^ 128'h5a5a_1234_a5a5_9876_0f0f_cafe_f0f0_beef;
   endfunction

   always_comb dec_out = core(dec_in);

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] expect_pt(input logic [127:0] c);
`ifdef AES_CBC_CHAIN_EN
      return core(c) ^ chain_m;
`else
      return core(c);
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per new plaintext, checks value, latency and hold stability
   logic [127:0] prev_pt = '0;
   logic         prev_v = 1'b0, prev_hs = 1'b0;
   exp_t         mon_e;
   always @(negedge clk) begin
      if (rst) begin
         prev_v  = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (pt_valid) begin
            if (prev_v && prev_hs) chk("pt_valid_drop", 128'(pt_valid), 128'd0);
            else if (prev_v) chk("pt_hold", pt, prev_pt);
            else if (exp_q.size() == 0) chk("spurious_pt_valid", 128'(pt_valid), 128'd0);
            else begin
               mon_e = exp_q.pop_front();
               chk("pt", pt, mon_e.pt);
               chk("latency", 128'(cyc), 128'(mon_e.cyc));
            end
         end
         prev_v  = pt_valid;
         prev_hs = pt_valid && pt_ready;
         prev_pt = pt;
      end
   end

   task automatic send(input logic [127:0] c, input bit with_iv, input logic [127:0] iv_in,
                       input int stall, input bit busy_iv);
      bit hs;
      int st;
      hs = 1'b0;
      st = stall;
      ct = c;
      ct_valid = 1'b1;
      if (with_iv) begin
         iv = iv_in;
         iv_load = 1'b1;
      end
      @(negedge clk);
`ifdef AES_CBC_CHAIN_EN
      chk("ct_ready_idle", 128'(ct_ready), 128'(!with_iv));
      if (with_iv) begin
         @(posedge clk); #1;
         iv_load = 1'b0;
         chain_m = iv_in;
         @(negedge clk);
         chk("ct_ready_after_iv", 128'(ct_ready), 128'd1);
      end
`else
      chk("ct_ready_idle", 128'(ct_ready), 128'd1);
`endif
      @(posedge clk); #1;
      iv_load = 1'b0;
      exp_q.push_back('{expect_pt(c), cyc + W});
`ifdef AES_CBC_CHAIN_EN
      chain_m = c;
`endif
      // keep offering junk while busy: it must not be taken
      ct = rnd128();
      for (int i = 0; i < 60 && !hs; i++) begin
         if (!pt_valid) pt_ready = 1'($urandom);
         else if (st > 0) begin
            pt_ready = 1'b0;
            st--;
         end else pt_ready = 1'b1;
         if (busy_iv && i == 1) begin
            iv_load = 1'b1;
            iv = rnd128();
         end
         @(negedge clk);
         chk("ct_ready_busy", 128'(ct_ready), 128'd0);
         chk("busy", 128'(busy), 128'd1);
         chk("dec_in_hold", dec_in, c);
         hs = pt_valid && pt_ready;
         @(posedge clk); #1;
         iv_load = 1'b0;
      end
      ct_valid = 1'b0;
      pt_ready = 1'b0;
      chk("handshake", 128'(hs), 128'd1);
   endtask

   task automatic abort_block(input logic [127:0] c, input int ncyc);
      exp_t junk;
      ct = c;
      ct_valid = 1'b1;
      pt_ready = 1'b0;
      @(negedge clk);
      chk("ct_ready_pre_abort", 128'(ct_ready), 128'd1);
      @(posedge clk); #1;
      ct_valid = 1'b0;
      exp_q.push_back('{expect_pt(c), cyc + W});
      repeat (ncyc) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_pt_valid", 128'(pt_valid), 128'd0);
      chk("rst_pt", pt, 128'd0);
      chk("rst_dec_in", dec_in, 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_ct_ready", 128'(ct_ready), 128'd1);
      if (exp_q.size() > 0) junk = exp_q.pop_back();
      chain_m = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      chk("reset_pt_valid", 128'(pt_valid), 128'd0);
      chk("reset_pt", pt, 128'd0);
      chk("reset_dec_in", dec_in, 128'd0);
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_ct_ready", 128'(ct_ready), 128'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      send(KAT_CT, 1'b1, 128'd0, 0, 1'b0);
      send(KAT_CT, 1'b0, 128'd0, 0, 1'b0);
      send(KAT_CT, 1'b1, '1, 0, 1'b0);
      send(rnd128(), 1'b0, 128'd0, 6, 1'b1);
      send(rnd128(), 1'b0, 128'd0, 0, 1'b0);
      abort_block(rnd128(), 1);
      abort_block(rnd128(), W);
      send(KAT_CT, 1'b0, 128'd0, 0, 1'b0);
      for (int n = 0; n < 24; n++)
         send(rnd128(), ($urandom % 4) == 0, rnd128(), int'($urandom_range(0, 3)), 1'($urandom));

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/aes_cbc_decrypt_chain.md
AES_CBC_DECRYPT_CHAIN -- requirements
Module: aes_cbc_decrypt_chain

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of clock cycles the decrypt datapath is given to settle (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iv_load  input  1  pulse; load chaining register from iv.
REQ-005 SHALL have port iv  input  128  initialisation vector.
REQ-006 SHALL have port ct_valid  input  1  ciphertext block offered.
REQ-007 SHALL have port ct_ready  output  1  block can accept ciphertext.
REQ-008 SHALL have port ct  input  128  ciphertext block.
REQ-009 SHALL have port dec_in  output  128  registered ciphertext, drives the combinational AES decrypt core input.
REQ-010 SHALL have port dec_out  input  128  AES decrypt core output.
REQ-011 SHALL have port pt_valid  output  1  plaintext block available.
REQ-012 SHALL have port pt_ready  input  1  downstream accepts plaintext.
REQ-013 SHALL have port pt  output  128  plaintext block, registered.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, OUT; 4-bit wait counter.
REQ-016 SHALL drive ct_ready = (state==IDLE) && !iv_load.
REQ-017 IDLE: iv_load=1 SHALL load chain <= iv at the clock edge; iv_load takes priority over a simultaneous ct_valid (ct not accepted that cycle).
REQ-018 iv_load in WAIT or OUT SHALL be ignored; chain unchanged.
REQ-019 IDLE with ct_valid && ct_ready: SHALL register dec_in <= ct, load counter with WAIT_CYCLES-1, go to WAIT.
REQ-020 WAIT: counter decrements each cycle; on the cycle the counter equals 0 SHALL capture pt <= dec_out XOR chain, chain <= dec_in, pt_valid <= 1, go to OUT.
REQ-021 Latency: acceptance edge k -> pt_valid high after edge k+WAIT_CYCLES; dec_in stable for all WAIT_CYCLES cycles.
REQ-022 OUT: pt and pt_valid SHALL hold stable until pt_ready=1; at that edge pt_valid <= 0, go to IDLE.
REQ-023 pt_ready while pt_valid=0 SHALL have no effect.
REQ-024 One block in flight max; no new ct accepted until the OUT handshake completes (throughput 1 block per WAIT_CYCLES+2 cycles minimum).
REQ-025 dec_in SHALL retain the last accepted ciphertext after leaving WAIT.
REQ-026 All XORs are bitwise 128-bit, bit 127 = first byte MSB, same byte order as AES core.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, chain 0, dec_in 0, pt 0, pt_valid 0, busy 0 (ct_ready then reflects !iv_load).
REQ-028 rst mid-WAIT or mid-OUT SHALL abort the block; no pt_valid emitted for it after rst deasserts.

Configuration
REQ-029 Macro AES_CBC_CHAIN_EN defined: CBC behaviour per REQ-017..REQ-020.
REQ-030 AES_CBC_CHAIN_EN undefined: ECB passthrough; pt <= dec_out, chain register, iv and iv_load logic SHALL not be built (iv, iv_load ignored), timing/handshake identical.

Verification (AES core key 000102030405060708090a0b0c0d0e0f, WAIT_CYCLES=2)
REQ-031 iv_load with iv=0, then ct=69c4e0d86a7b0430d8cdb78070b4c55a, pt_ready=1 -> pt=00112233445566778899aabbccddeeff, pt_valid 2 cycles after acceptance, high 1 cycle.
REQ-032 iv=ffffffffffffffffffffffffffffffff, same ct -> pt=ffeeddccbbaa99887766554433221100.
REQ-033 iv=0, same ct sent twice back-to-back -> second pt=69d5c2eb2e2e624750541d3bbc692ba5 (chained on first ct).
REQ-034 pt_ready held 0 for 5 cycles in OUT -> pt/pt_valid stable, ct_ready=0, iv_load pulse ignored (next block still chains on prior ct).
REQ-035 iv_load and ct_valid same IDLE cycle -> ct_ready=0, iv loaded, ct accepted next cycle.
REQ-036 rst asserted in WAIT -> all outputs zero immediately, no pt_valid afterwards; without AES_CBC_CHAIN_EN, REQ-032 stimulus gives 00112233445566778899aabbccddeeff.
